// File: rtl/datapath_types.sv
// Shared front-end datapath types.
//   word_t         : 32-bit machine word
//   fetch_entry_t  : one buffered fetch result {pc, instr, pred_taken}
//   fetch_state_t  : fetch controller states
package datapath_types;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
    logic  pred_taken;
  } fetch_entry_t;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries feeding dispatch.
// Ports:
//   CLK, nRST   : clock, synchronous active-low reset
//   push/data   : enqueue one entry (ignored when full)
//   pop         : dequeue head entry (ignored when empty)
//   clear       : drop all entries; wins over push and pop
//   head        : current head entry (from registers)
//   full, empty : occupancy flags
//   count       : number of valid entries, 0..DEPTH
module fetch_queue
  import datapath_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     clear,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // NOTE: storage array is not reset; entries are only observed once
  // count says they are valid, so resetting them buys nothing.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Front-end fetch controller: owns the fetch PC, issues I-memory requests
// under a stable-address handshake, consults the branch predictor and
// buffers fetched instructions for dispatch. Handles flush/mispredict
// redirects, discarding a response that is already in flight.
// Ports:
//   CLK, nRST                 : clock, synchronous active-low reset
//   imem_req/addr/ready/rdata : instruction memory handshake
//   bp_pc/taken/target        : branch predictor lookup
//   mispredict/correct_pc     : branch unit redirect
//   flush/flush_pc            : pipeline flush redirect (higher priority)
//   halt                      : stop issuing new requests
//   dispatch_free             : dispatch consumes the head this cycle
//   instr_valid/instr/instr_pc/instr_pred_taken : queue head
//   q_count                   : queue occupancy
module fetch_ctrl
  import datapath_types::*;
#(
  parameter int    DEPTH    = 4,
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic                   CLK,
  input  logic                   nRST,
  output logic                   imem_req,
  output word_t                  imem_addr,
  input  logic                   imem_ready,
  input  word_t                  imem_rdata,
  output word_t                  bp_pc,
  input  logic                   bp_taken,
  input  word_t                  bp_target,
  input  logic                   mispredict,
  input  word_t                  correct_pc,
  input  logic                   flush,
  input  word_t                  flush_pc,
  input  logic                   halt,
  input  logic                   dispatch_free,
  output logic                   instr_valid,
  output word_t                  instr,
  output word_t                  instr_pc,
  output logic                   instr_pred_taken,
  output logic [$clog2(DEPTH):0] q_count
);

  fetch_state_t state_q, state_d;
  word_t        fetch_pc_q, fetch_pc_d;
  word_t        held_addr_q;
  logic         outstanding_q;

  logic         redirect;
  word_t        redirect_pc;
  logic         accept;
  logic         q_push;
  logic         q_pop;
  logic         q_full;
  logic         q_empty;
  fetch_entry_t q_head;
  fetch_entry_t q_in;

  assign redirect    = flush || mispredict;
  assign redirect_pc = flush ? flush_pc : correct_pc;

  // Once raised, a request stays up until ready, independent of halt/full.
  // DISCARD always has a request outstanding, so it is covered too.
  assign imem_req  = nRST && (outstanding_q || (state_q == DISCARD) || (!q_full && !halt));
  // While outstanding, the address comes from the held copy so PC updates
  // from redirects cannot disturb the in-flight request.
  assign imem_addr = outstanding_q ? held_addr_q : fetch_pc_q;
  assign bp_pc     = imem_addr;

  assign accept = imem_req && imem_ready;
  assign q_push = accept && (state_q == FETCH) && !redirect;
  assign q_in   = '{pc: fetch_pc_q, instr: imem_rdata, pred_taken: bp_taken};

  assign instr_valid      = nRST && !q_empty;
  assign q_pop            = instr_valid && dispatch_free;
  assign instr            = q_head.instr;
  assign instr_pc         = q_head.pc;
  assign instr_pred_taken = q_head.pred_taken;

  // NOTE: every output of this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          // Memory cannot abort: wait out the response with the old address.
          if (imem_req && !imem_ready) state_d = DISCARD;
        end else if (accept) begin
          fetch_pc_d = bp_taken ? bp_target : fetch_pc_q + 32'd4;
        end
      end
      DISCARD: begin
        if (redirect)   fetch_pc_d = redirect_pc;
        if (imem_ready) state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      held_addr_q   <= RESET_PC;
      outstanding_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      held_addr_q   <= imem_addr;
      outstanding_q <= imem_req && !imem_ready;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .clear     (redirect),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl (DEPTH=4, RESET_PC=0x100). The memory model
// returns addr ^ 0xA5A50000 so the head instruction identifies its PC.
module tb_fetch_ctrl;
  import datapath_types::*;

  localparam int    DEPTH  = 4;
  localparam word_t RST_PC = 32'h0000_0100;
  localparam word_t SALT   = 32'hA5A5_0000;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imem_req;
  word_t       imem_addr;
  logic        imem_ready;
  word_t       imem_rdata;
  word_t       bp_pc;
  logic        bp_taken;
  word_t       bp_target;
  logic        mispredict;
  word_t       correct_pc;
  logic        flush;
  word_t       flush_pc;
  logic        halt;
  logic        dispatch_free;
  logic        instr_valid;
  word_t       instr;
  word_t       instr_pc;
  logic        instr_pred_taken;
  logic [2:0]  q_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  assign imem_rdata = imem_addr ^ SALT;

  fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .bp_pc            (bp_pc),
    .bp_taken         (bp_taken),
    .bp_target        (bp_target),
    .mispredict       (mispredict),
    .correct_pc       (correct_pc),
    .flush            (flush),
    .flush_pc         (flush_pc),
    .halt             (halt),
    .dispatch_free    (dispatch_free),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_pred_taken (instr_pred_taken),
    .q_count          (q_count)
  );

  typedef struct {
    logic  rst_n;
    logic  rdy;
    logic  bpt;
    word_t tgt;
    logic  dfree;
    logic  hlt;
    logic  fl;
    word_t fpc;
    logic  mis;
    word_t cpc;
    logic  e_req;
    word_t e_addr;
    logic  e_valid;
    word_t e_ipc;
    logic  e_pt;
    int    e_cnt;
  } vec_t;

  function automatic vec_t mkv(
    input logic rst_n, input logic rdy, input logic bpt, input word_t tgt,
    input logic dfree, input logic hlt, input logic fl, input word_t fpc,
    input logic mis, input word_t cpc,
    input logic e_req, input word_t e_addr, input logic e_valid,
    input word_t e_ipc, input logic e_pt, input int e_cnt);
    vec_t v;
    v.rst_n = rst_n; v.rdy = rdy; v.bpt = bpt; v.tgt = tgt;
    v.dfree = dfree; v.hlt = hlt; v.fl = fl; v.fpc = fpc;
    v.mis = mis; v.cpc = cpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_ipc = e_ipc; v.e_pt = e_pt; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, compare just after, then the rising
  // edge commits the cycle.
  task automatic run_vec(input string tag, input int idx, input vec_t v);
    string p;
    @(negedge CLK);
    nRST          = v.rst_n;
    imem_ready    = v.rdy;
    bp_taken      = v.bpt;
    bp_target     = v.tgt;
    dispatch_free = v.dfree;
    halt          = v.hlt;
    flush         = v.fl;
    flush_pc      = v.fpc;
    mispredict    = v.mis;
    correct_pc    = v.cpc;
    #1;
    p = $sformatf("%s[%0d]", tag, idx);
    check({p, ".imem_req"},    32'(imem_req),    32'(v.e_req));
    check({p, ".imem_addr"},   imem_addr,        v.e_addr);
    check({p, ".bp_pc"},       bp_pc,            v.e_addr);
    check({p, ".instr_valid"}, 32'(instr_valid), 32'(v.e_valid));
    check({p, ".q_count"},     32'(q_count),     32'(v.e_cnt));
    if (v.e_valid) begin
      check({p, ".instr_pc"},   instr_pc,              v.e_ipc);
      check({p, ".instr"},      instr,                 v.e_ipc ^ SALT);
      check({p, ".pred_taken"}, 32'(instr_pred_taken), 32'(v.e_pt));
    end
  endtask

  vec_t tbl [13];

  initial begin
    nRST = 1'b0; imem_ready = 1'b0; bp_taken = 1'b0; bp_target = '0;
    dispatch_free = 1'b1; halt = 1'b0; flush = 1'b0; flush_pc = '0;
    mispredict = 1'b0; correct_pc = '0;

    //            rst rdy bpt tgt         df hl fl fpc mis cpc | req addr          vld ipc           pt cnt
    // Reset, then streaming hits (test 1) and a predicted-taken branch (test 2).
    tbl[0]  = mkv(0, 0, 0, 0,            1, 0, 0, 0, 0, 0,   0, 32'h100, 0, 0,            0, 0);
    tbl[1]  = mkv(0, 0, 0, 0,            1, 0, 0, 0, 0, 0,   0, 32'h100, 0, 0,            0, 0);
    tbl[2]  = mkv(1, 1, 0, 0,            1, 0, 0, 0, 0, 0,   1, 32'h100, 0, 0,            0, 0);
    tbl[3]  = mkv(1, 1, 0, 0,            1, 0, 0, 0, 0, 0,   1, 32'h104, 1, 32'h100,      0, 1);
    tbl[4]  = mkv(1, 1, 1, 32'h400,      1, 0, 0, 0, 0, 0,   1, 32'h108, 1, 32'h104,      0, 1);
    tbl[5]  = mkv(1, 1, 0, 0,            1, 0, 0, 0, 0, 0,   1, 32'h400, 1, 32'h108,      1, 1);
    // Dispatch stalls: queue fills to DEPTH and the request drops (test 3).
    tbl[6]  = mkv(1, 1, 0, 0,            0, 0, 0, 0, 0, 0,   1, 32'h404, 1, 32'h400,      0, 1);
    tbl[7]  = mkv(1, 1, 0, 0,            0, 0, 0, 0, 0, 0,   1, 32'h408, 1, 32'h400,      0, 2);
    tbl[8]  = mkv(1, 1, 0, 0,            0, 0, 0, 0, 0, 0,   1, 32'h40C, 1, 32'h400,      0, 3);
    tbl[9]  = mkv(1, 1, 0, 0,            0, 0, 0, 0, 0, 0,   0, 32'h410, 1, 32'h400,      0, 4);
    tbl[10] = mkv(1, 1, 0, 0,            1, 0, 0, 0, 0, 0,   0, 32'h410, 1, 32'h400,      0, 4);
    tbl[11] = mkv(1, 1, 0, 0,            0, 0, 0, 0, 0, 0,   1, 32'h410, 1, 32'h404,      0, 3);
    tbl[12] = mkv(1, 1, 0, 0,            0, 0, 0, 0, 0, 0,   0, 32'h414, 1, 32'h404,      0, 4);

    for (int i = 0; i < 13; i++) run_vec("tbl", i, tbl[i]);

    // Mispredict while 0x10C is outstanding with ready delayed (test 4).
    run_vec("misp", 0, mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 32'h414, 0, 0, 0, 4));
    run_vec("misp", 1, mkv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,       1, 32'h100, 0, 0, 0, 0));
    run_vec("misp", 2, mkv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,       1, 32'h104, 1, 32'h100, 0, 1));
    run_vec("misp", 3, mkv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,       1, 32'h108, 1, 32'h100, 0, 2));
    run_vec("misp", 4, mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,       1, 32'h10C, 1, 32'h100, 0, 3));
    run_vec("misp", 5, mkv(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 1, 32'h10C, 1, 32'h100, 0, 3));
    run_vec("misp", 6, mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,       1, 32'h10C, 0, 0, 0, 0));
    run_vec("misp", 7, mkv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,       1, 32'h10C, 0, 0, 0, 0));
    run_vec("misp", 8, mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,       1, 32'h200, 0, 0, 0, 0));

    // Flush and mispredict together with ready and a pop pending (test 5).
    run_vec("flush", 0, mkv(1, 1, 0, 0, 1, 0, 0, 0, 0, 0,             1, 32'h200, 0, 0, 0, 0));
    run_vec("flush", 1, mkv(1, 1, 0, 0, 1, 0, 1, 32'h300, 1, 32'h200, 1, 32'h204, 1, 32'h200, 0, 1));
    run_vec("flush", 2, mkv(1, 0, 0, 0, 1, 0, 0, 0, 0, 0,             1, 32'h300, 0, 0, 0, 0));

    // Reset in the middle of DISCARD (test 6).
    run_vec("rstd", 0, mkv(1, 0, 0, 0, 1, 0, 1, 32'h500, 0, 0, 1, 32'h300, 0, 0, 0, 0));
    run_vec("rstd", 1, mkv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0,       0, 32'h300, 0, 0, 0, 0));
    run_vec("rstd", 2, mkv(1, 0, 0, 0, 1, 0, 0, 0, 0, 0,       1, 32'h100, 0, 0, 0, 0));

    // halt keeps the outstanding request, then blocks new ones; redirect
    // with nothing outstanding shows the new PC on the next cycle.
    run_vec("halt", 0, mkv(1, 0, 0, 0, 1, 1, 0, 0, 0, 0,       1, 32'h100, 0, 0, 0, 0));
    run_vec("halt", 1, mkv(1, 1, 0, 0, 1, 1, 0, 0, 0, 0,       1, 32'h100, 0, 0, 0, 0));
    run_vec("halt", 2, mkv(1, 0, 0, 0, 1, 1, 0, 0, 0, 0,       0, 32'h104, 1, 32'h100, 0, 1));
    run_vec("halt", 3, mkv(1, 0, 0, 0, 1, 1, 1, 32'h600, 0, 0, 0, 32'h104, 0, 0, 0, 0));
    run_vec("halt", 4, mkv(1, 0, 0, 0, 1, 1, 0, 0, 0, 0,       0, 32'h600, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
